// File: rtl/cpu_trace_pkg.sv
// Shared types, constants and character-class helpers for the trace checker.
package cpu_trace_pkg;

  // Parser states; the suffix-0 states wait for the first digit of a field.
  typedef enum logic [3:0] {
    S_IDLE,
    S_TIME0,
    S_TIME,
    S_PC0,
    S_PC,
    S_SEP,
    S_REG0,
    S_REG,
    S_ADDR0,
    S_ADDR,
    S_ARROW_SP,
    S_ARROW_EQ,
    S_DATA_SP,
    S_DATA
  } state_t;

  // Reported line formats.
  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  // Bit positions inside the error vector.
  localparam int ERR_TIME = 0;
  localparam int ERR_PC   = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_REG  = 3;
  localparam int ERR_ZREG = 4;
  localparam int ERR_W    = 5;

  // Punctuation recognised by the parser.
  localparam logic [7:0] CH_CARET  = 8'h5E; // ^
  localparam logic [7:0] CH_AT     = 8'h40; // @
  localparam logic [7:0] CH_COLON  = 8'h3A; // :
  localparam logic [7:0] CH_DOLLAR = 8'h24; // $
  localparam logic [7:0] CH_STAR   = 8'h2A; // *
  localparam logic [7:0] CH_SP     = 8'h20; // space
  localparam logic [7:0] CH_LT     = 8'h3C; // <
  localparam logic [7:0] CH_EQ     = 8'h3D; // =
  localparam logic [7:0] CH_HASH   = 8'h23; // #

  // Decimal digit '0'..'9'.
  function automatic logic is_dec(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Lowercase hex digit; uppercase letters are deliberately rejected.
  function automatic logic is_hex(input logic [7:0] c);
    return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Nibble value of a digit that already passed is_dec or is_hex.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    if (is_dec(c)) begin
      return c[3:0];
    end
    return c[3:0] + 4'd9; // 'a' = 0x61 -> 1 + 9 = 10
  endfunction

endpackage

// File: rtl/cpu_trace_checker_num_acc.sv
// Digit accumulator shared by every numeric field of a trace line.
// A clear together with a shift loads the first digit of a new field.
module trace_num_acc
  import cpu_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_dec_i,
  input  logic        shift_hex_i,
  input  logic [7:0]  char_i,
  output logic [31:0] value_o,
  output logic [3:0]  count_o
);

  logic [31:0] value_q, value_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] base_value;
  logic [3:0]  base_count;
  logic [3:0]  digit;

  // Next value: start from zero on clear, then fold in the new digit.
  always_comb begin
    digit      = hex_val(char_i);
    base_value = clear_i ? 32'd0 : value_q;
    base_count = clear_i ? 4'd0 : count_q;
    value_d    = base_value;
    count_d    = base_count;
    if (shift_dec_i) begin
      value_d = base_value * 32'd10 + {28'd0, digit};
      count_d = base_count + 4'd1;
    end else if (shift_hex_i) begin
      value_d = {base_value[27:0], digit};
      count_d = base_count + 4'd1;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 32'd0;
      count_q <= 4'd0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value_o = value_q;
  assign count_o = count_q;

endmodule

// File: rtl/cpu_trace_checker.sv
// Streaming checker for CPU write-back trace lines, one character per clock.
// Parses register and memory write lines, accumulates field errors and
// emits a one-cycle report with format, errors and a saturating line count.
module cpu_trace_checker
  import cpu_trace_pkg::*;
#(
  parameter int          HEX_DIGITS  = 8,
  parameter int          TIME_DIGITS = 4,
  parameter int          REG_DIGITS  = 4,
  parameter int          NUM_REGS    = 32,
  parameter logic [31:0] PC_LO       = 32'h3000,
  parameter logic [31:0] PC_HI       = 32'h4fff,
  parameter logic [31:0] ADDR_LO     = 32'h0,
  parameter logic [31:0] ADDR_HI     = 32'h2fff,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic [15:0]      freq,
  output logic [1:0]       format_type,
  output logic [4:0]       error_code,
  output logic             line_valid,
  output logic [CNT_W-1:0] line_count
);

  localparam logic [3:0]  HEX_LIM  = 4'(HEX_DIGITS);
  localparam logic [3:0]  TIME_LIM = 4'(TIME_DIGITS);
  localparam logic [3:0]  REG_LIM  = 4'(REG_DIGITS);
  localparam logic [31:0] REG_MAX  = 32'(NUM_REGS);

  state_t           state_q, state_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       fmt_q, fmt_d;
  logic             reg_zero_q, reg_zero_d;

  logic             acc_clear, acc_dec, acc_hex;
  logic [31:0]      acc_value;
  logic [3:0]       acc_count;

  logic             report;
  logic [ERR_W-1:0] report_err;
  logic [15:0]      time_mask;
  logic             c_dec, c_hex, c_sp;

  logic             line_valid_q;
  logic [1:0]       format_q;
  logic [ERR_W-1:0] error_q;
  logic [CNT_W-1:0] line_count_q;

  trace_num_acc u_acc (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (acc_clear),
    .shift_dec_i (acc_dec),
    .shift_hex_i (acc_hex),
    .char_i      (char),
    .value_o     (acc_value),
    .count_o     (acc_count)
  );

  // Next-state, accumulator control and field checks at each field close.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    fmt_d      = fmt_q;
    reg_zero_d = reg_zero_q;
    acc_clear  = 1'b0;
    acc_dec    = 1'b0;
    acc_hex    = 1'b0;
    report     = 1'b0;
    report_err = err_q;
    c_dec      = is_dec(char);
    c_hex      = is_hex(char);
    c_sp       = (char == CH_SP);
    time_mask  = (freq >> 1) - 16'd1;

    if (char == CH_CARET) begin
      // Start of line, or resync from anywhere: drop any partial line.
      state_d    = S_TIME0;
      err_d      = '0;
      fmt_d      = FMT_NONE;
      reg_zero_d = 1'b0;
      acc_clear  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;

        S_TIME0: begin
          if (c_dec) begin
            acc_clear = 1'b1;
            acc_dec   = 1'b1;
            state_d   = S_TIME;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_TIME: begin
          if (c_dec && (acc_count < TIME_LIM)) begin
            acc_dec = 1'b1;
          end else if (char == CH_AT) begin
            // freq is only looked at here; below 2 the time check is off.
            if (freq >= 16'd2) begin
              err_d[ERR_TIME] = (acc_value & {16'd0, time_mask}) != 32'd0;
            end
            state_d = S_PC0;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_PC0: begin
          if (c_hex) begin
            acc_clear = 1'b1;
            acc_hex   = 1'b1;
            state_d   = S_PC;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_PC: begin
          if (c_hex && (acc_count < HEX_LIM)) begin
            acc_hex = 1'b1;
          end else if ((char == CH_COLON) && (acc_count == HEX_LIM)) begin
            err_d[ERR_PC] = (acc_value[1:0] != 2'b00) ||
                            (acc_value < PC_LO) || (acc_value > PC_HI);
            state_d = S_SEP;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_SEP: begin
          if (c_sp) begin
            state_d = S_SEP;
          end else if (char == CH_DOLLAR) begin
            fmt_d   = FMT_REG;
            state_d = S_REG0;
          end else if (char == CH_STAR) begin
            fmt_d   = FMT_MEM;
            state_d = S_ADDR0;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_REG0: begin
          if (c_dec) begin
            acc_clear = 1'b1;
            acc_dec   = 1'b1;
            state_d   = S_REG;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_REG: begin
          if (c_dec && (acc_count < REG_LIM)) begin
            acc_dec = 1'b1;
          end else if (c_sp || (char == CH_LT)) begin
            // Remember a $0 target; the data value decides at '#'.
            err_d[ERR_REG] = acc_value >= REG_MAX;
            reg_zero_d     = (acc_value == 32'd0);
            state_d        = c_sp ? S_ARROW_SP : S_ARROW_EQ;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_ADDR0: begin
          if (c_hex) begin
            acc_clear = 1'b1;
            acc_hex   = 1'b1;
            state_d   = S_ADDR;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_ADDR: begin
          if (c_hex && (acc_count < HEX_LIM)) begin
            acc_hex = 1'b1;
          end else if ((c_sp || (char == CH_LT)) && (acc_count == HEX_LIM)) begin
            err_d[ERR_ADDR] = (acc_value[1:0] != 2'b00) ||
                              (acc_value < ADDR_LO) || (acc_value > ADDR_HI);
            state_d = c_sp ? S_ARROW_SP : S_ARROW_EQ;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_ARROW_SP: begin
          if (c_sp) begin
            state_d = S_ARROW_SP;
          end else if (char == CH_LT) begin
            state_d = S_ARROW_EQ;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_ARROW_EQ: state_d = (char == CH_EQ) ? S_DATA_SP : S_IDLE;

        S_DATA_SP: begin
          if (c_sp) begin
            state_d = S_DATA_SP;
          end else if (c_hex) begin
            acc_clear = 1'b1;
            acc_hex   = 1'b1;
            state_d   = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_DATA: begin
          if (c_hex && (acc_count < HEX_LIM)) begin
            acc_hex = 1'b1;
          end else if ((char == CH_HASH) && (acc_count == HEX_LIM)) begin
            report = 1'b1;
            report_err[ERR_ZREG] = (fmt_q == FMT_REG) && reg_zero_q &&
                                   (acc_value != 32'd0);
            state_d = S_IDLE;
          end else begin
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Parser state and pending per-line information.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      err_q      <= '0;
      fmt_q      <= FMT_NONE;
      reg_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      fmt_q      <= fmt_d;
      reg_zero_q <= reg_zero_d;
    end
  end

  // Report pulse outputs and the saturating well-formed line counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid_q <= 1'b0;
      format_q     <= FMT_NONE;
      error_q      <= '0;
      line_count_q <= '0;
    end else begin
      line_valid_q <= report;
      format_q     <= report ? fmt_q : FMT_NONE;
      error_q      <= report ? report_err : '0;
      if (report && (line_count_q != {CNT_W{1'b1}})) begin
        line_count_q <= line_count_q + CNT_W'(1);
      end
    end
  end

  assign line_valid  = line_valid_q;
  assign format_type = format_q;
  assign error_code  = error_q;
  assign line_count  = line_count_q;

endmodule
